// File: rtl/udma_eth_rx_frame_ctrl.sv
// uDMA ethernet RX channel config registers plus frame-length descriptor queue.
// Tracks received frame lengths and stalls RX when software falls behind.
module udma_eth_rx_frame_ctrl #(
    parameter int          L2_AWIDTH_NOAL = 12,
    parameter int          TRANS_SIZE     = 16,
    parameter int          RX_FIFO_DEPTH  = 1024,
    parameter int          NUM_DESC       = 4,
    parameter int          LEN_W          = 16,
    parameter logic [31:0] VERSION        = 32'h0002_0001,
    parameter int          FIFO_LOG       = $clog2(RX_FIFO_DEPTH),
    parameter int          DESC_LOG       = $clog2(NUM_DESC)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [31:0]               cfg_data_i,
    input  logic [4:0]                cfg_addr_i,
    input  logic                      cfg_valid_i,
    input  logic                      cfg_rwn_i,
    output logic [31:0]               cfg_data_o,
    output logic                      cfg_ready_o,
    output logic [L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_o,
    output logic [TRANS_SIZE-1:0]     cfg_rx_size_o,
    output logic                      cfg_rx_continuous_o,
    output logic                      cfg_rx_en_o,
    output logic                      cfg_rx_clr_o,
    input  logic                      cfg_rx_en_i,
    input  logic                      cfg_rx_pending_i,
    input  logic [L2_AWIDTH_NOAL-1:0] cfg_rx_curr_addr_i,
    input  logic [TRANS_SIZE-1:0]     cfg_rx_bytes_left_i,
    input  logic                      rx_byte_valid_i,
    input  logic                      rx_eof_i,
    input  logic [FIFO_LOG:0]         rx_fifo_elements_i,
    output logic                      rx_blocked_o,
    output logic                      irq_o
);

    localparam logic [4:0] A_SADDR  = 5'h00;
    localparam logic [4:0] A_SIZE   = 5'h01;
    localparam logic [4:0] A_CFG    = 5'h02;
    localparam logic [4:0] A_WHOAMI = 5'h03;
    localparam logic [4:0] A_FCFG   = 5'h07;
    localparam logic [4:0] A_FIFON  = 5'h08;
    localparam logic [4:0] A_FSTAT  = 5'h09;
    localparam logic [4:0] A_FHEAD  = 5'h0A;
    localparam logic [4:0] A_FPOP   = 5'h0B;

    localparam logic [DESC_LOG:0]  DESC_FULL = (DESC_LOG+1)'(NUM_DESC);
    localparam logic [FIFO_LOG:0]  FIFO_FULL = (FIFO_LOG+1)'(RX_FIFO_DEPTH);
    localparam logic [LEN_W-1:0]   LEN_MAX   = {LEN_W{1'b1}};

    logic [L2_AWIDTH_NOAL-1:0] saddr_q, saddr_d;
    logic [TRANS_SIZE-1:0]     size_q, size_d;
    logic                      cont_q, cont_d;
    logic                      en_p_q, en_p_d;
    logic                      clr_p_q, clr_p_d;
    logic                      mode_q, mode_d;
    logic                      irq_en_q, irq_en_d;
    logic                      force_blk_q, force_blk_d;
    logic                      legacy_blk_q, legacy_blk_d;
    logic                      ovf_q, ovf_d;
    logic                      irq_q, irq_d;
    logic                      eof_q;
    logic [LEN_W-1:0]          byte_cnt_q, byte_cnt_d;
    logic [DESC_LOG:0]         count_q, count_d;
    logic [DESC_LOG-1:0]       head_q, head_d;
    logic [DESC_LOG-1:0]       tail_q, tail_d;
    logic [LEN_W-1:0]          desc_q [NUM_DESC];

    logic             wr_en, rd_en;
    logic             eof_ev, full, empty;
    logic             push, pop, drop;
    logic [LEN_W-1:0] frame_len;
    logic             unused_w;

    assign wr_en  = cfg_valid_i & ~cfg_rwn_i;
    assign rd_en  = cfg_valid_i & cfg_rwn_i;
    assign eof_ev = rx_eof_i & ~eof_q;
    assign full   = (count_q == DESC_FULL);
    assign empty  = (count_q == '0);
    assign push   = eof_ev & ~full;
    assign drop   = eof_ev & full;
    assign pop    = wr_en & (cfg_addr_i == A_FPOP) & ~empty;

    // Length of the frame closing now, counting a byte arriving this cycle
    assign frame_len = (byte_cnt_q == LEN_MAX) ? LEN_MAX
                     : byte_cnt_q + LEN_W'(rx_byte_valid_i);

    assign unused_w = ^cfg_data_i;

    // Next-state for config, frame tracking and blocking state
    always_comb begin
        saddr_d      = saddr_q;
        size_d       = size_q;
        cont_d       = cont_q;
        en_p_d       = 1'b0;
        clr_p_d      = 1'b0;
        mode_d       = mode_q;
        irq_en_d     = irq_en_q;
        force_blk_d  = force_blk_q;
        legacy_blk_d = legacy_blk_q;
        ovf_d        = ovf_q;
        count_d      = count_q;
        head_d       = head_q;
        tail_d       = tail_q;
        byte_cnt_d   = byte_cnt_q;
        irq_d        = irq_en_q & ~empty;

        if (wr_en) begin
            case (cfg_addr_i)
                A_SADDR: saddr_d = cfg_data_i[L2_AWIDTH_NOAL-1:0];
                A_SIZE:  size_d  = cfg_data_i[TRANS_SIZE-1:0];
                A_CFG: begin
                    cont_d  = cfg_data_i[0];
                    en_p_d  = cfg_data_i[4];
                    clr_p_d = cfg_data_i[6];
                end
                A_FCFG: begin
                    mode_d      = cfg_data_i[1];
                    irq_en_d    = cfg_data_i[2];
                    force_blk_d = cfg_data_i[0];
                    if (!cfg_data_i[0]) legacy_blk_d = 1'b0;
                end
                A_FSTAT: if (cfg_data_i[17]) ovf_d = 1'b0;
                default: ;
            endcase
        end

        if (rx_byte_valid_i && byte_cnt_q != LEN_MAX)
            byte_cnt_d = byte_cnt_q + 1'b1;
        if (eof_ev) begin
            byte_cnt_d = '0;
            if (!mode_q) legacy_blk_d = 1'b1;
        end
        if (drop) ovf_d = 1'b1;

        if (push) tail_d = tail_q + 1'b1;
        if (pop)  head_d = head_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            saddr_q      <= '0;
            size_q       <= '0;
            cont_q       <= 1'b0;
            en_p_q       <= 1'b0;
            clr_p_q      <= 1'b0;
            mode_q       <= 1'b0;
            irq_en_q     <= 1'b0;
            force_blk_q  <= 1'b0;
            legacy_blk_q <= 1'b0;
            ovf_q        <= 1'b0;
            irq_q        <= 1'b0;
            eof_q        <= 1'b0;
            byte_cnt_q   <= '0;
            count_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            for (int i = 0; i < NUM_DESC; i++) desc_q[i] <= '0;
        end else begin
            saddr_q      <= saddr_d;
            size_q       <= size_d;
            cont_q       <= cont_d;
            en_p_q       <= en_p_d;
            clr_p_q      <= clr_p_d;
            mode_q       <= mode_d;
            irq_en_q     <= irq_en_d;
            force_blk_q  <= force_blk_d;
            legacy_blk_q <= legacy_blk_d;
            ovf_q        <= ovf_d;
            irq_q        <= irq_d;
            eof_q        <= rx_eof_i;
            byte_cnt_q   <= byte_cnt_d;
            count_q      <= count_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            if (push) desc_q[tail_q] <= frame_len;
        end
    end

    // Combinational register read mux
    always_comb begin
        cfg_data_o = '0;
        if (rd_en) begin
            case (cfg_addr_i)
                A_SADDR:  cfg_data_o[L2_AWIDTH_NOAL-1:0] = cfg_rx_curr_addr_i;
                A_SIZE:   cfg_data_o[TRANS_SIZE-1:0] = cfg_rx_bytes_left_i;
                A_CFG: begin
                    cfg_data_o[5] = cfg_rx_pending_i;
                    cfg_data_o[4] = cfg_rx_en_i;
                    cfg_data_o[0] = cont_q;
                end
                A_WHOAMI: cfg_data_o = VERSION;
                A_FCFG: begin
                    cfg_data_o[0] = rx_blocked_o;
                    cfg_data_o[1] = mode_q;
                    cfg_data_o[2] = irq_en_q;
                    cfg_data_o[3] = (rx_fifo_elements_i == FIFO_FULL);
                end
                A_FIFON:  cfg_data_o[FIFO_LOG:0] = rx_fifo_elements_i;
                A_FSTAT: begin
                    cfg_data_o[DESC_LOG:0] = count_q;
                    cfg_data_o[16] = full;
                    cfg_data_o[17] = ovf_q;
                end
                A_FHEAD: begin
                    cfg_data_o[31] = ~empty;
                    if (!empty) cfg_data_o[LEN_W-1:0] = desc_q[head_q];
                end
                default: ;
            endcase
        end
    end

    assign cfg_ready_o         = 1'b1;
    assign cfg_rx_startaddr_o  = saddr_q;
    assign cfg_rx_size_o       = size_q;
    assign cfg_rx_continuous_o = cont_q;
    assign cfg_rx_en_o         = en_p_q;
    assign cfg_rx_clr_o        = clr_p_q;
    assign rx_blocked_o        = force_blk_q | legacy_blk_q | (mode_q & full);
    assign irq_o               = irq_q;

endmodule

// File: tb/tb_udma_eth_rx_frame_ctrl.sv
// Scoreboard bench for udma_eth_rx_frame_ctrl: stimulus queues expectations,
// a negedge monitor pops and compares whenever a read or probe is presented.
module tb_udma_eth_rx_frame_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] cfg_data_i;
    logic [4:0]  cfg_addr_i;
    logic        cfg_valid_i;
    logic        cfg_rwn_i;
    logic [31:0] cfg_data_o;
    logic        cfg_ready_o;
    logic [11:0] cfg_rx_startaddr_o;
    logic [15:0] cfg_rx_size_o;
    logic        cfg_rx_continuous_o;
    logic        cfg_rx_en_o;
    logic        cfg_rx_clr_o;
    logic        cfg_rx_en_i;
    logic        cfg_rx_pending_i;
    logic [11:0] cfg_rx_curr_addr_i;
    logic [15:0] cfg_rx_bytes_left_i;
    logic        rx_byte_valid_i;
    logic        rx_eof_i;
    logic [10:0] rx_fifo_elements_i;
    logic        rx_blocked_o;
    logic        irq_o;

    udma_eth_rx_frame_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_data_i(cfg_data_i), .cfg_addr_i(cfg_addr_i),
        .cfg_valid_i(cfg_valid_i), .cfg_rwn_i(cfg_rwn_i),
        .cfg_data_o(cfg_data_o), .cfg_ready_o(cfg_ready_o),
        .cfg_rx_startaddr_o(cfg_rx_startaddr_o),
        .cfg_rx_size_o(cfg_rx_size_o),
        .cfg_rx_continuous_o(cfg_rx_continuous_o),
        .cfg_rx_en_o(cfg_rx_en_o), .cfg_rx_clr_o(cfg_rx_clr_o),
        .cfg_rx_en_i(cfg_rx_en_i), .cfg_rx_pending_i(cfg_rx_pending_i),
        .cfg_rx_curr_addr_i(cfg_rx_curr_addr_i),
        .cfg_rx_bytes_left_i(cfg_rx_bytes_left_i),
        .rx_byte_valid_i(rx_byte_valid_i), .rx_eof_i(rx_eof_i),
        .rx_fifo_elements_i(rx_fifo_elements_i),
        .rx_blocked_o(rx_blocked_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    localparam int S_RD   = 0;
    localparam int S_BLK  = 1;
    localparam int S_IRQ  = 2;
    localparam int S_PLS  = 3;
    localparam int S_CONT = 4;
    localparam int S_BUS  = 5;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic probe    = 1'b0;
    int   probe_sel = 0;

    // Monitor: compare the presented output against the oldest expectation
    always @(negedge clk_i) begin
        if ((cfg_valid_i && cfg_rwn_i) || probe) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output: no expectation queued");
            end else begin
                exp_t        e;
                logic [31:0] act;
                e = sb.pop_front();
                case (e.sel)
                    S_RD:    act = cfg_data_o;
                    S_BLK:   act = {31'b0, rx_blocked_o};
                    S_IRQ:   act = {31'b0, irq_o};
                    S_PLS:   act = {30'b0, cfg_rx_clr_o, cfg_rx_en_o};
                    S_CONT:  act = {31'b0, cfg_rx_continuous_o};
                    default: act = cfg_data_o;
                endcase
                if (act !== e.exp) begin
                    failures++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h",
                             e.name, act, e.exp);
                end
            end
        end
    end

    // All tasks start and end at posedge+1
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cfg_valid_i = 1'b1;
        cfg_rwn_i   = 1'b0;
        cfg_addr_i  = a;
        cfg_data_i  = d;
        tick();
        cfg_valid_i = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e,
                      input string n);
        sb.push_back('{n, S_RD, e});
        cfg_valid_i = 1'b1;
        cfg_rwn_i   = 1'b1;
        cfg_addr_i  = a;
        tick();
        cfg_valid_i = 1'b0;
        cfg_rwn_i   = 1'b0;
    endtask

    task automatic chk(input int s, input logic [31:0] e, input string n);
        sb.push_back('{n, s, e});
        probe = 1'b1;
        tick();
        probe = 1'b0;
    endtask

    task automatic bytes(input int n);
        for (int i = 0; i < n; i++) begin
            rx_byte_valid_i = 1'b1;
            tick();
        end
        rx_byte_valid_i = 1'b0;
    endtask

    task automatic frame(input int n);
        bytes(n);
        rx_eof_i = 1'b1;
        tick();
        rx_eof_i = 1'b0;
    endtask

    // Frame end coincident with a register write in the EOF edge cycle
    task automatic frame_wr(input int n, input logic [4:0] a,
                            input logic [31:0] d);
        bytes(n);
        rx_eof_i    = 1'b1;
        cfg_valid_i = 1'b1;
        cfg_rwn_i   = 1'b0;
        cfg_addr_i  = a;
        cfg_data_i  = d;
        tick();
        rx_eof_i    = 1'b0;
        cfg_valid_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1;
        cfg_data_i = '0; cfg_addr_i = '0;
        cfg_valid_i = 1'b0; cfg_rwn_i = 1'b0;
        cfg_rx_en_i = 1'b0; cfg_rx_pending_i = 1'b0;
        cfg_rx_curr_addr_i = 12'hABC; cfg_rx_bytes_left_i = 16'h1234;
        rx_byte_valid_i = 1'b0; rx_eof_i = 1'b0;
        rx_fifo_elements_i = '0;
        repeat (3) tick();
        rst_i = 1'b0;
        tick();

        // Reset state
        rd(5'h03, 32'h0002_0001, "whoami");
        rd(5'h09, 32'h0, "stat_reset");
        chk(S_BLK, 32'h0, "blk_reset");
        chk(S_IRQ, 32'h0, "irq_reset");
        chk(S_BUS, 32'h0, "rdata_idle");
        rd(5'h05, 32'h0, "unmapped_rd");
        rd(5'h00, 32'h0000_0ABC, "curr_addr");
        rd(5'h01, 32'h0000_1234, "bytes_left");

        // Channel config pulses
        wr(5'h02, 32'h51);
        chk(S_PLS, 32'h3, "pulse_on");
        chk(S_PLS, 32'h0, "pulse_off");
        chk(S_CONT, 32'h1, "continuous");
        cfg_rx_en_i = 1'b1;
        rd(5'h02, 32'h11, "rx_cfg_rd");

        // Multi-frame mode with interrupt
        wr(5'h07, 32'h6);
        frame(60);
        frame(1514);
        rd(5'h09, 32'h2, "stat_two");
        rd(5'h0A, 32'h8000_003C, "head_60");
        chk(S_IRQ, 32'h1, "irq_on");
        wr(5'h0B, 32'h0);
        rd(5'h0A, 32'h8000_05EA, "head_1514");
        wr(5'h0B, 32'h0);
        chk(S_IRQ, 32'h1, "irq_lag");
        chk(S_IRQ, 32'h0, "irq_off");
        rd(5'h09, 32'h0, "stat_empty");
        rd(5'h0A, 32'h0, "head_empty");

        // Fill, overflow, recover
        for (int i = 1; i <= 4; i++) frame(i);
        chk(S_BLK, 32'h1, "blk_full");
        rd(5'h09, 32'h0001_0004, "stat_full");
        frame(5);
        rd(5'h09, 32'h0003_0004, "stat_ovf");
        wr(5'h0B, 32'h0);
        chk(S_BLK, 32'h0, "blk_after_pop");
        rd(5'h0A, 32'h8000_0002, "head_after_ovf");
        wr(5'h09, 32'h0002_0000);
        rd(5'h09, 32'h3, "ovf_clr");
        for (int i = 0; i < 4; i++) wr(5'h0B, 32'h0);
        rd(5'h09, 32'h0, "pop_empty");

        // Legacy mode blocking
        wr(5'h07, 32'h0);
        frame(64);
        chk(S_BLK, 32'h1, "legacy_blk");
        rx_fifo_elements_i = 11'd1024;
        rd(5'h07, 32'h9, "fcfg_rd");
        rd(5'h08, 32'h400, "fifo_n");
        rx_fifo_elements_i = 11'd10;
        rd(5'h07, 32'h1, "fcfg_notfull");
        wr(5'h07, 32'h0);
        chk(S_BLK, 32'h0, "legacy_rel");
        frame_wr(10, 5'h07, 32'h0);
        chk(S_BLK, 32'h1, "set_wins");
        wr(5'h07, 32'h0);
        chk(S_BLK, 32'h0, "legacy_rel2");
        rd(5'h09, 32'h2, "stat_legacy");

        // Pop coincident with push at count 2
        frame_wr(7, 5'h0B, 32'h0);
        rd(5'h09, 32'h2, "stat_pushpop");
        rd(5'h0A, 32'h8000_000A, "head_pushpop");
        wr(5'h0B, 32'h0);
        rd(5'h0A, 32'h8000_0007, "tail_pushpop");

        // Reset mid-frame
        frame(4);
        bytes(5);
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        rd(5'h09, 32'h0, "stat_rst");
        rd(5'h07, 32'h0, "fcfg_rst");
        chk(S_BLK, 32'h0, "blk_rst");
        wr(5'h07, 32'h2);
        frame(3);
        rd(5'h0A, 32'h8000_0003, "head_rst");

        tick();
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL sb_drain: %0d left expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
